fft_sample_buf: RTL and testbench

- Parametrised sample buffer for the FFT datapath. Replaces the fixed 1024x16 RAM and its free-running wave counter.
- Random-access port: the FFT engine or loader writes samples and reads them back.
- Playback port: streams a programmable run of samples out over a valid/ready handshake, one-shot or looping. Feeds the DAC/wave monitor or the next pipeline stage.

---
 rtl/fft_sample_buf.sv | 175 +++++++++++++++++
 tb/tb_fft_sample_buf.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_buf.sv
`default_nettype none
// ============================================================================
// fft_sample_buf : sample RAM with a registered random-access port and a
// valid/ready playback port. FFT_BUF_BITREV_EN enables bit-reversed fetching.
// Revision 1.0
// ============================================================================
module fft_sample_buf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              pb_start_i,
  input  logic [ADDR_W:0]   pb_len_i,
  input  logic              pb_loop_i,
  input  logic              pb_stop_i,
`ifdef FFT_BUF_BITREV_EN
  input  logic              pb_bitrev_i,
`endif
  input  logic              pb_ready_i,
  output logic              pb_valid_o,
  output logic [DATA_W-1:0] pb_data_o,
  output logic              pb_last_o,
  output logic [ADDR_W-1:0] pb_idx_o,
  output logic              pb_busy_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   fptr_q, fptr_d;
  logic              loop_q, loop_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, pb_data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              start_ok, fetch, xfer, more, at_end;
  logic [ADDR_W-1:0] lin_addr, fetch_addr;

  assign start_ok = (state_q == IDLE) && pb_start_i && (pb_len_i != '0);
  assign lin_addr = fptr_q[ADDR_W-1:0];
  assign xfer     = valid_q && pb_ready_i;
  assign more     = loop_q || (fptr_q < len_q);
  assign at_end   = (fptr_q == (len_q - LEN_ONE));
  assign fetch    = (state_q == RUN) && !pb_stop_i && (!valid_q || pb_ready_i) && more;

`ifdef FFT_BUF_BITREV_EN
  logic              bitrev_q, bitrev_d;
  logic [ADDR_W-1:0] rev_addr;

  assign bitrev_d = start_ok ? pb_bitrev_i : bitrev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bitrev_q <= 1'b0;
    else        bitrev_q <= bitrev_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_bitrev
      assign rev_addr[gi] = lin_addr[ADDR_W-1-gi];
    end
  endgenerate

  assign fetch_addr = bitrev_q ? rev_addr : lin_addr;
`else
  assign fetch_addr = lin_addr;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    loop_d  = loop_q;
    fptr_d  = fptr_q;
    valid_d = valid_q;
    last_d  = last_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
          // Lengths at or above the depth all clamp to a full pass.
          len_d   = pb_len_i[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : pb_len_i;
          loop_d  = pb_loop_i;
          fptr_d  = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (pb_stop_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          if (fetch) begin
            valid_d = 1'b1;
            idx_d   = lin_addr;
            last_d  = at_end;
            fptr_d  = (at_end && loop_q) ? '0 : fptr_q + LEN_ONE;
          end else if (xfer) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
          if (xfer && last_q && !loop_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      loop_q  <= 1'b0;
      fptr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      fptr_q  <= fptr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Storage is never reset; reads below see pre-write contents on a collision.
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      pb_data_q <= '0;
    end else begin
      data_q <= mem[addr_i];
      if (fetch) pb_data_q <= mem[fetch_addr];
    end
  end

  assign data_o     = data_q;
  assign pb_valid_o = valid_q;
  assign pb_data_o  = pb_data_q;
  assign pb_last_o  = last_q;
  assign pb_idx_o   = idx_q;
  assign pb_busy_o  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_sample_buf.sv
`default_nettype none
// Self-checking bench for fft_sample_buf: vector table for the random-access
// port, reference-model checking of randomized playback runs.
module tb_fft_sample_buf;
`ifdef FFT_BUF_BITREV_EN
  localparam int AW = 3;
`else
  localparam int AW = 10;
`endif
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk, rst_n, we_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] data_i, data_o;
  logic          pb_start_i, pb_loop_i, pb_stop_i, pb_ready_i;
  logic [AW:0]   pb_len_i;
  logic          pb_valid_o, pb_last_o, pb_busy_o;
  logic [DW-1:0] pb_data_o;
  logic [AW-1:0] pb_idx_o;
`ifdef FFT_BUF_BITREV_EN
  logic          pb_bitrev_i;
`endif

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] model_mem [DEPTH];

  fft_sample_buf #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .pb_start_i(pb_start_i), .pb_len_i(pb_len_i),
    .pb_loop_i(pb_loop_i), .pb_stop_i(pb_stop_i),
`ifdef FFT_BUF_BITREV_EN
    .pb_bitrev_i(pb_bitrev_i),
`endif
    .pb_ready_i(pb_ready_i), .pb_valid_o(pb_valid_o), .pb_data_o(pb_data_o),
    .pb_last_o(pb_last_o), .pb_idx_o(pb_idx_o), .pb_busy_o(pb_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    int          addr;
    logic [15:0] data;
    bit          chk;
    logic [15:0] exp;
  } ra_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev(input int k);
    int r = 0;
    for (int b = 0; b < AW; b++)
      if (((k >> b) & 1) == 1) r = r | (1 << (AW - 1 - b));
    return r;
  endfunction

  task automatic ra_write(input int a, input logic [DW-1:0] d);
    we_i = 1'b1; addr_i = a[AW-1:0]; data_i = d;
    tick();
    we_i = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_o"}, data_o, 0);
    check({tag, "_pb_data"}, pb_data_o, 0);
    check({tag, "_valid"}, pb_valid_o, 0);
    check({tag, "_last"}, pb_last_o, 0);
    check({tag, "_idx"}, pb_idx_o, 0);
    check({tag, "_busy"}, pb_busy_o, 0);
  endtask

  // Accepted stream k must be sample (k mod len) of the pass, in linear or
  // bit-reversed memory order; the offered sample is checked every valid cycle.
  task automatic play(input int len, input bit loop, input int n_acc, input int rdy_pct,
                      input bit brev, input bit poke_start);
    int eff, k, cyc, j, a;
    bit rdy, use_rev;
    eff = (len > DEPTH) ? DEPTH : len;
`ifdef FFT_BUF_BITREV_EN
    use_rev = brev;
    pb_bitrev_i = brev;
`else
    use_rev = 1'b0;
`endif
    pb_start_i = 1'b1; pb_len_i = len[AW:0]; pb_loop_i = loop; pb_ready_i = 1'b0;
    tick();
    pb_start_i = 1'b0;
`ifdef FFT_BUF_BITREV_EN
    pb_bitrev_i = ~brev;
`endif
    check("start_busy", pb_busy_o, 1);
    check("start_novalid", pb_valid_o, 0);
    tick();
    check("first_valid", pb_valid_o, 1);
    k = 0; cyc = 0;
    while (k < n_acc && cyc < 8 * n_acc + 64) begin
      if (rdy_pct >= 100) check("throughput", pb_valid_o, 1);
      if (pb_valid_o) begin
        j = k % eff;
        a = use_rev ? rev(j) : j;
        check("pb_idx", pb_idx_o, j);
        check("pb_data", pb_data_o, model_mem[a]);
        check("pb_last", pb_last_o, (j == eff - 1) ? 1 : 0);
      end
      rdy = ($urandom_range(0, 99) < rdy_pct);
      pb_ready_i = rdy;
      pb_start_i = poke_start && (cyc == 2);
      if (pb_start_i) begin pb_len_i = 1; pb_loop_i = 1'b0; end
      if (pb_valid_o && rdy) k++;
      tick();
      cyc++;
    end
    pb_start_i = 1'b0; pb_ready_i = 1'b0;
    if (k < n_acc) check("pb_timeout", k, n_acc);
    if (!loop) begin
      check("end_valid", pb_valid_o, 0);
      check("end_busy", pb_busy_o, 0);
      check("end_last", pb_last_o, 0);
    end else begin
      pb_stop_i = 1'b1; pb_ready_i = 1'b1;
      tick();
      pb_stop_i = 1'b0; pb_ready_i = 1'b0;
      check("stop_valid", pb_valid_o, 0);
      check("stop_busy", pb_busy_o, 0);
      check("stop_last", pb_last_o, 0);
      tick();
      check("stop_stays_idle", pb_valid_o, 0);
    end
  endtask

  initial begin
    ra_vec_t vecs [10];
    int len, lp;

    vecs[0] = '{1'b1, 3, 16'h1234, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 3, 16'h0000, 1'b1, 16'h1234};
    vecs[2] = '{1'b1, 3, 16'hBEEF, 1'b1, 16'h1234};
    vecs[3] = '{1'b0, 3, 16'h0000, 1'b1, 16'hBEEF};
    vecs[4] = '{1'b1, 6, 16'h00A5, 1'b0, 16'h0000};
    vecs[5] = '{1'b1, 7, 16'h5A5A, 1'b0, 16'h0000};
    vecs[6] = '{1'b0, 6, 16'h0000, 1'b1, 16'h00A5};
    vecs[7] = '{1'b0, 7, 16'h0000, 1'b1, 16'h5A5A};
    vecs[8] = '{1'b1, 6, 16'hFFFF, 1'b1, 16'h00A5};
    vecs[9] = '{1'b0, 6, 16'h0000, 1'b1, 16'hFFFF};

    rst_n = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
    pb_start_i = 1'b0; pb_len_i = '0; pb_loop_i = 1'b0; pb_stop_i = 1'b0; pb_ready_i = 1'b0;
`ifdef FFT_BUF_BITREV_EN
    pb_bitrev_i = 1'b0;
`endif
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      we_i = vecs[i].we; addr_i = vecs[i].addr[AW-1:0]; data_i = vecs[i].data;
      tick();
      if (vecs[i].chk) check($sformatf("ra_vec%0d", i), data_o, vecs[i].exp);
      if (vecs[i].we) model_mem[vecs[i].addr] = vecs[i].data;
    end
    we_i = 1'b0;

    for (int i = 0; i < DEPTH; i++) ra_write(i, i[DW-1:0]);

    // len = 0 is ignored.
    pb_start_i = 1'b1; pb_len_i = '0; pb_loop_i = 1'b0; pb_ready_i = 1'b1;
    tick();
    pb_start_i = 1'b0;
    check("len0_busy", pb_busy_o, 0);
    tick();
    check("len0_valid", pb_valid_o, 0);
    pb_ready_i = 1'b0;

    play(4, 1'b0, 4, 100, 1'b0, 1'b0);
    play(8, 1'b0, 8, 50, 1'b0, 1'b0);
    play(3, 1'b1, 8, 100, 1'b0, 1'b1);
    play(2 * DEPTH - 1, 1'b0, DEPTH, 100, 1'b0, 1'b0);
`ifdef FFT_BUF_BITREV_EN
    play(8, 1'b0, 8, 100, 1'b1, 1'b0);
    play(8, 1'b1, 12, 60, 1'b1, 1'b0);
`endif

    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 8; w++) ra_write($urandom_range(0, DEPTH - 1), DW'($urandom));
      len = $urandom_range(1, (DEPTH < 20) ? DEPTH : 20);
      lp = $urandom_range(0, 1);
      play(len, lp[0], (lp != 0) ? 2 * len + 1 : len, $urandom_range(30, 90),
           $urandom_range(0, 1) != 0, 1'b0);
    end

    // Asynchronous reset mid-stream; storage survives it.
    ra_write(5, 16'hC0DE);
    pb_start_i = 1'b1; pb_len_i = 4; pb_loop_i = 1'b1; pb_ready_i = 1'b1;
    tick();
    pb_start_i = 1'b0;
    tick(); tick(); tick();
    check("pre_reset_valid", pb_valid_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    rst_n = 1'b1; addr_i = 5;
    tick();
    check("mem_survives_reset", data_o, 16'hC0DE);
    check("post_reset_valid", pb_valid_o, 0);
    tick();
    check("post_reset_busy", pb_busy_o, 0);
    check("post_reset_valid2", pb_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
